// File: rtl/key_matrix_scanner.sv
// rtl/key_matrix_scanner.sv - keypad matrix scanner with frame debounce, ghost detect, roll-over
// Optional auto-repeat enabled by defining KEY_REPEAT_EN.
module key_matrix_scanner #(
    parameter int N_COLS       = 3,
    parameter int N_ROWS       = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE     = 4,
    parameter int REPEAT_DELAY = 30,
    parameter int REPEAT_RATE  = 8,
    localparam int CODE_W      = $clog2(N_ROWS * N_COLS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_ROWS-1:0] key_row,
    output logic [N_COLS-1:0] key_col,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_press,
    output logic              key_release,
    output logic              multi_key
);

    localparam int N_KEYS = N_ROWS * N_COLS;
    localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W  = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {CAND_NONE, CAND_KEY, CAND_MULTI} cand_t;
    typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_ROLL} state_t;

    logic [DIV_W-1:0]  div_cnt;
    logic [N_ROWS-1:0] row_meta;
    logic [N_ROWS-1:0] row_sync;
    logic [N_KEYS-1:0] frame_buf;
    logic [N_KEYS-1:0] frame_now;
    logic              sample_en;
    logic              frame_tick;

    logic [1:0]        key_cnt;
    logic [CODE_W-1:0] hit_code;
    cand_t             cand_kind;
    logic [CODE_W-1:0] cand_code;
    cand_t             prev_kind;
    logic [CODE_W-1:0] prev_code;
    logic [CNT_W-1:0]  stab_cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              commit;

    state_t            state, state_d;
    logic [CODE_W-1:0] roll_code, roll_code_d;
    logic [CODE_W-1:0] key_code_d;
    logic              key_valid_d, key_press_d, key_release_d;

    assign sample_en  = (div_cnt == DIV_LAST);
    assign frame_tick = sample_en & key_col[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            key_col  <= N_COLS'(1) << (N_COLS - 1);
            row_meta <= '0;
            row_sync <= '0;
        end else begin
            row_meta <= key_row;
            row_sync <= row_meta;
            if (sample_en) begin
                div_cnt <= '0;
                key_col <= {key_col[0], key_col[N_COLS-1:1]};
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // Frame as it stands including the column being sampled this cycle, indexed by key code.
    always_comb begin
        frame_now = frame_buf;
        for (int r = 0; r < N_ROWS; r++) begin
            for (int c = 0; c < N_COLS; c++) begin
                if (key_col[c]) begin
                    frame_now[(N_ROWS - 1 - r) * N_COLS + (N_COLS - 1 - c)] = row_sync[r];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_buf <= '0;
        end else if (sample_en) begin
            frame_buf <= frame_now;
        end
    end

    always_comb begin
        key_cnt  = 2'd0;
        hit_code = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            if (frame_now[k]) begin
                hit_code = CODE_W'(k);
                if (key_cnt != 2'd2) key_cnt = key_cnt + 2'd1;
            end
        end
        cand_kind = CAND_NONE;
        cand_code = '0;
        if (key_cnt == 2'd1) begin
            cand_kind = CAND_KEY;
            cand_code = hit_code;
        end else if (key_cnt == 2'd2) begin
            cand_kind = CAND_MULTI;
        end
    end

    // Non-key candidates carry code 0, so a plain compare covers all three kinds.
    always_comb begin
        cnt_next = CNT_ONE;
        if (cand_kind == prev_kind && cand_code == prev_code) begin
            cnt_next = (stab_cnt >= DEB_MAX) ? DEB_MAX : stab_cnt + 1'b1;
        end
    end

    assign commit = frame_tick && (cnt_next == DEB_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_kind <= CAND_NONE;
            prev_code <= '0;
            stab_cnt  <= '0;
            multi_key <= 1'b0;
        end else if (frame_tick) begin
            prev_kind <= cand_kind;
            prev_code <= cand_code;
            stab_cnt  <= cnt_next;
            multi_key <= (cand_kind == CAND_MULTI);
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DELAY_C = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_RATE_C  = REP_W'(REPEAT_RATE);

    logic [REP_W-1:0] rep_cnt, rep_cnt_d, rep_inc, rep_target;
    logic             rep_armed, rep_armed_d;

    assign rep_inc    = rep_cnt + 1'b1;
    assign rep_target = rep_armed ? REP_RATE_C : REP_DELAY_C;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else begin
            rep_cnt   <= rep_cnt_d;
            rep_armed <= rep_armed_d;
        end
    end
`endif

    always_comb begin
        state_d       = state;
        roll_code_d   = roll_code;
        key_code_d    = key_code;
        key_valid_d   = key_valid;
        key_press_d   = 1'b0;
        key_release_d = 1'b0;
`ifdef KEY_REPEAT_EN
        rep_cnt_d     = rep_cnt;
        rep_armed_d   = rep_armed;
`endif
        case (state)
            S_IDLE: begin
`ifdef KEY_REPEAT_EN
                rep_cnt_d   = '0;
                rep_armed_d = 1'b0;
`endif
                if (commit && cand_kind == CAND_KEY) begin
                    key_code_d  = cand_code;
                    key_valid_d = 1'b1;
                    key_press_d = 1'b1;
                    state_d     = S_PRESSED;
                end
            end
            S_PRESSED: begin
                if (commit) begin
                    if (cand_kind == CAND_NONE) begin
                        key_release_d = 1'b1;
                        key_valid_d   = 1'b0;
                        state_d       = S_IDLE;
                    end else if (cand_kind == CAND_KEY && cand_code != key_code) begin
                        key_release_d = 1'b1;
                        roll_code_d   = cand_code;
                        state_d       = S_ROLL;
                    end
`ifdef KEY_REPEAT_EN
                    else if (cand_kind == CAND_MULTI) begin
                        rep_cnt_d   = '0;
                        rep_armed_d = 1'b0;
                    end else if (rep_inc == rep_target) begin
                        key_press_d = 1'b1;
                        rep_cnt_d   = '0;
                        rep_armed_d = 1'b1;
                    end else begin
                        rep_cnt_d = rep_inc;
                    end
`endif
                end
            end
            S_ROLL: begin
`ifdef KEY_REPEAT_EN
                rep_cnt_d   = '0;
                rep_armed_d = 1'b0;
`endif
                key_code_d  = roll_code;
                key_press_d = 1'b1;
                state_d     = S_PRESSED;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            roll_code   <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state       <= state_d;
            roll_code   <= roll_code_d;
            key_code    <= key_code_d;
            key_valid   <= key_valid_d;
            key_press   <= key_press_d;
            key_release <= key_release_d;
        end
    end

endmodule

// File: tb/tb_key_matrix_scanner.sv
// tb/tb_key_matrix_scanner.sv - self-checking bench for key_matrix_scanner (3x4, SCAN_DIV=4, DEBOUNCE=3)
module tb_key_matrix_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  key_row;
    logic [2:0]  key_col;
    logic [3:0]  key_code;
    logic        key_valid, key_press, key_release, multi_key;
    logic [11:0] mask = '0;

    int total = 0;
    int bad = 0;

`ifdef KEY_REPEAT_EN
    localparam int REP_PRESSES = 5;
`else
    localparam int REP_PRESSES = 1;
`endif

    typedef struct {
        logic       is_press;
        logic [3:0] code;
    } ev_t;

    typedef struct {
        logic [11:0] mask;
        int          frames;
        bit          rel;
        int          rel_code;
        int          presses;
        int          code;
        bit          valid;
        bit          multi;
    } step_t;

    ev_t   exp_q[$];
    ev_t   mon_e;
    step_t steps[$];

    key_matrix_scanner #(
        .N_COLS(3), .N_ROWS(4), .SCAN_DIV(4), .DEBOUNCE(3),
        .REPEAT_DELAY(4), .REPEAT_RATE(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_row(key_row), .key_col(key_col),
        .key_code(key_code), .key_valid(key_valid), .key_press(key_press),
        .key_release(key_release), .multi_key(multi_key)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key with code r*3+c shorts row (3-r) to column (2-c).
    always_comb begin
        key_row = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (mask[r * 3 + c] && key_col[2 - c]) key_row[3 - r] = 1'b1;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (key_press || key_release)) begin
            check("press_release_exclusive", int'(key_press & key_release), 0);
            if (exp_q.size() == 0) begin
                check("spurious_event", int'({key_press, key_release}), 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_is_press", int'(key_press), int'(mon_e.is_press));
                check("event_code", int'(key_code), int'(mon_e.code));
            end
        end
    end

    task automatic wait_frames(input int n);
        logic [2:0] last;
        bit         seen;
        for (int f = 0; f < n; f++) begin
            last = key_col;
            seen = 0;
            for (int k = 0; k < 100 && !seen; k++) begin
                @(posedge clk);
                #1;
                if (key_col == 3'b100 && last == 3'b001) seen = 1;
                last = key_col;
            end
            if (!seen) begin
                check("frame_timeout", 0, 1);
                return;
            end
        end
    endtask

    task automatic run_step(input int idx, input step_t s);
        ev_t e;
        mask = s.mask;
        if (s.rel) begin
            e.is_press = 1'b0;
            e.code = 4'(s.rel_code);
            exp_q.push_back(e);
        end
        for (int i = 0; i < s.presses; i++) begin
            e.is_press = 1'b1;
            e.code = 4'(s.code);
            exp_q.push_back(e);
        end
        wait_frames(s.frames);
        check($sformatf("step%0d_pending_events", idx), exp_q.size(), 0);
        check($sformatf("step%0d_key_valid", idx), int'(key_valid), int'(s.valid));
        check($sformatf("step%0d_key_code", idx), int'(key_code), s.code);
        check($sformatf("step%0d_multi_key", idx), int'(multi_key), int'(s.multi));
    endtask

    function automatic step_t mk(input logic [11:0] m, input int f, input bit rel, input int rc,
                                 input int np, input int cd, input bit v, input bit mu);
        step_t s;
        s.mask = m; s.frames = f; s.rel = rel; s.rel_code = rc;
        s.presses = np; s.code = cd; s.valid = v; s.multi = mu;
        return s;
    endfunction

    initial begin
        step_t s;
        // mask, frames, release?, release code, presses, code after, valid, multi
        steps.push_back(mk(12'h000, 4, 0, 0, 0, 0, 0, 0));
        steps.push_back(mk(12'h010, 10, 0, 0, 1, 4, 1, 0));
        steps.push_back(mk(12'h000, 4, 1, 4, 0, 4, 0, 0));
        for (int i = 0; i < 8; i++)
            steps.push_back(mk((i % 2 == 0) ? 12'h100 : 12'h000, 1, 0, 0, 0, 4, 0, 0));
        steps.push_back(mk(12'h000, 4, 0, 0, 0, 4, 0, 0));
        steps.push_back(mk(12'h011, 5, 0, 0, 0, 4, 0, 1));
        steps.push_back(mk(12'h000, 4, 0, 0, 0, 4, 0, 0));
        steps.push_back(mk(12'h010, 5, 0, 0, 1, 4, 1, 0));
        steps.push_back(mk(12'h011, 5, 0, 0, 0, 4, 1, 1));
        steps.push_back(mk(12'h010, 5, 0, 0, 0, 4, 1, 0));
        steps.push_back(mk(12'h001, 5, 1, 4, 1, 0, 1, 0));
        steps.push_back(mk(12'h000, 5, 1, 0, 0, 0, 0, 0));
        steps.push_back(mk(12'h080, 14, 0, 0, REP_PRESSES, 7, 1, 0));
        steps.push_back(mk(12'h000, 4, 1, 7, 0, 7, 0, 0));
        steps.push_back(mk(12'h800, 5, 0, 0, 1, 11, 1, 0));
        steps.push_back(mk(12'h000, 4, 1, 11, 0, 11, 0, 0));

        repeat (3) @(posedge clk);
        #1;
        check("reset_key_col", int'(key_col), 4);
        check("reset_key_code", int'(key_code), 0);
        check("reset_flags", int'({key_valid, key_press, key_release, multi_key}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rotate_col1", int'(key_col), 2);
        repeat (4) @(posedge clk);
        #1;
        check("rotate_col0", int'(key_col), 1);
        repeat (4) @(posedge clk);
        #1;
        check("rotate_wrap", int'(key_col), 4);

        foreach (steps[i]) run_step(i, steps[i]);

        // Reset while a key is committed: everything clears with no release pulse.
        run_step(100, mk(12'h020, 5, 0, 0, 1, 5, 1, 0));
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_key_col", int'(key_col), 4);
        check("midreset_key_code", int'(key_code), 0);
        check("midreset_flags", int'({key_valid, key_press, key_release, multi_key}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        s = mk(12'h020, 0, 0, 0, 1, 5, 1, 0);
        exp_q.push_back('{is_press: 1'b1, code: 4'd5});
        wait_frames(4);
        check("postreset_pending", exp_q.size(), 0);
        check("postreset_key_valid", int'(key_valid), int'(s.valid));
        check("postreset_key_code", int'(key_code), s.code);
        run_step(101, mk(12'h000, 4, 1, 5, 0, 5, 0, 0));

        repeat (4) @(posedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
